// File: rtl/glb_psum_reader_if.sv
// GLB read port plus output word stream of the psum reader.
// master: reader side; slave: GLB + stream consumer side.
interface glb_psum_reader_if #(
    parameter int DATA_BITWIDTH = 32,
    parameter int BANK_W        = 2,
    parameter int ADDR_W        = 13
);
    logic [BANK_W-1:0]        o_glb_bank_sel;
    logic                     o_glb_re;
    logic [ADDR_W-1:0]        o_glb_ra;
    logic [DATA_BITWIDTH-1:0] i_glb_rd;
    logic [DATA_BITWIDTH-1:0] o_data;
    logic                     o_valid;
    logic                     i_ready;
    logic                     o_last;

    modport master (
        output o_glb_bank_sel, o_glb_re, o_glb_ra,
        input  i_glb_rd,
        output o_data, o_valid, o_last,
        input  i_ready
    );

    modport slave (
        input  o_glb_bank_sel, o_glb_re, o_glb_ra,
        output i_glb_rd,
        input  o_data, o_valid, o_last,
        output i_ready
    );
endinterface

// File: rtl/glb_psum_reader.sv
// GLB readback engine: streams num_elem words of one bank out on valid/ready.
// Ports: i_clk, i_rst (sync, active-low), start/bank/base/num_elem command,
// o_busy, o_done, bus (GLB read port + stream, glb_psum_reader_if.master).
// Optional GLB_PSUM_READER_CHECKSUM_EN adds o_checksum (sum of sent words).
module glb_psum_reader #(
    parameter int DATA_BITWIDTH = 32,
    parameter int BANK_NUM      = 3,
    parameter int BANK_DEPTH    = 8192,
    parameter int LEN_BITWIDTH  = 14,
    localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
    localparam int ADDR_W = $clog2(BANK_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [BANK_W-1:0]        i_bank,
    input  logic [ADDR_W-1:0]        i_base_addr,
    input  logic [LEN_BITWIDTH-1:0]  i_num_elem,
    output logic                     o_busy,
    output logic                     o_done,
`ifdef GLB_PSUM_READER_CHECKSUM_EN
    output logic [DATA_BITWIDTH-1:0] o_checksum,
`endif
    glb_psum_reader_if.master        bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [LEN_BITWIDTH-1:0] LEN_ONE = LEN_BITWIDTH'(1);

    state_t                    state;
    logic [LEN_BITWIDTH-1:0]   num_q;
    logic [LEN_BITWIDTH-1:0]   issue_idx;
    logic [LEN_BITWIDTH-1:0]   emit_idx;
    logic [DATA_BITWIDTH-1:0]  fifo_mem [2];
    logic                      rd_ptr;
    logic                      wr_ptr;
    logic [1:0]                cnt;
    logic [1:0]                cnt_nx;
    // pend: a read word sits on i_glb_rd and is not yet in the FIFO
    logic                      pend;
    logic                      pend_nx;
    logic                      push;
    logic                      pop;
    logic                      can_issue;
`ifdef GLB_PSUM_READER_CHECKSUM_EN
    logic [DATA_BITWIDTH-1:0]  csum;
    assign o_checksum = csum;
`endif

    assign bus.o_valid = (cnt != 2'd0);
    assign bus.o_data  = fifo_mem[rd_ptr];
    assign bus.o_last  = bus.o_valid && (emit_idx == num_q - LEN_ONE);

    assign pop  = bus.o_valid && bus.i_ready;
    // The GLB output holds while no read is issued, so a returning word
    // may wait there one extra cycle when the FIFO is full.
    assign push = pend && ((cnt != 2'd2) || pop);

    always_comb begin
        cnt_nx = cnt;
        if (push && !pop) begin
            cnt_nx = cnt + 2'd1;
        end else if (!push && pop) begin
            cnt_nx = cnt - 2'd1;
        end
    end

    assign pend_nx = bus.o_glb_re || (pend && !push);
    // Never issue while a word waits on the GLB port and the FIFO is full:
    // the new read would overwrite it before it could be captured.
    assign can_issue = !(pend_nx && (cnt_nx == 2'd2));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state              <= IDLE;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            bus.o_glb_re       <= 1'b0;
            bus.o_glb_ra       <= '0;
            bus.o_glb_bank_sel <= '0;
            num_q              <= '0;
            issue_idx          <= '0;
            emit_idx           <= '0;
            fifo_mem[0]        <= '0;
            fifo_mem[1]        <= '0;
            rd_ptr             <= 1'b0;
            wr_ptr             <= 1'b0;
            cnt                <= 2'd0;
            pend               <= 1'b0;
`ifdef GLB_PSUM_READER_CHECKSUM_EN
            csum               <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            pend   <= pend_nx;
            cnt    <= cnt_nx;
            if (push) begin
                fifo_mem[wr_ptr] <= bus.i_glb_rd;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                emit_idx <= emit_idx + LEN_ONE;
`ifdef GLB_PSUM_READER_CHECKSUM_EN
                csum     <= csum + bus.o_data;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        issue_idx <= '0;
                        emit_idx  <= '0;
`ifdef GLB_PSUM_READER_CHECKSUM_EN
                        csum      <= '0;
`endif
                        if (i_num_elem == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state              <= RUN;
                            o_busy             <= 1'b1;
                            num_q              <= i_num_elem;
                            bus.o_glb_bank_sel <= i_bank;
                            bus.o_glb_ra       <= i_base_addr;
                            bus.o_glb_re       <= 1'b1;
                            issue_idx          <= LEN_ONE;
                        end
                    end
                end
                RUN: begin
                    if (issue_idx == num_q) begin
                        bus.o_glb_re <= 1'b0;
                        state        <= DRAIN;
                    end else if (can_issue) begin
                        bus.o_glb_re <= 1'b1;
                        bus.o_glb_ra <= bus.o_glb_ra + ADDR_W'(1);
                        issue_idx    <= issue_idx + LEN_ONE;
                    end else begin
                        bus.o_glb_re <= 1'b0;
                    end
                end
                DRAIN: begin
                    bus.o_glb_re <= 1'b0;
                    if (pop && bus.o_last) begin
                        state              <= DONE;
                        o_done             <= 1'b1;
                        o_busy             <= 1'b0;
                        bus.o_glb_bank_sel <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_glb_psum_reader.sv
// Bench for glb_psum_reader: table vectors, random runs, reset abort.
// Expected stream is taken from the GLB memory image by address arithmetic.
module tb_glb_psum_reader;
    localparam int DW = 32;
    localparam int BN = 3;
    localparam int BD = 8192;
    localparam int LW = 14;
    localparam int BW = 2;
    localparam int AW = 13;

    typedef struct {
        int bank;
        int base;
        int num;
        int rmode;
        bit restart;
    } vec_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_start = 1'b0;
    logic [BW-1:0] i_bank = '0;
    logic [AW-1:0] i_base_addr = '0;
    logic [LW-1:0] i_num_elem = '0;
    logic          o_busy;
    logic          o_done;
`ifdef GLB_PSUM_READER_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    int n_cmp;
    int n_bad;

    glb_psum_reader_if #(.DATA_BITWIDTH(DW), .BANK_W(BW), .ADDR_W(AW)) bus();

    glb_psum_reader #(
        .DATA_BITWIDTH(DW), .BANK_NUM(BN),
        .BANK_DEPTH(BD), .LEN_BITWIDTH(LW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_bank      (i_bank),
        .i_base_addr (i_base_addr),
        .i_num_elem  (i_num_elem),
        .o_busy      (o_busy),
        .o_done      (o_done),
`ifdef GLB_PSUM_READER_CHECKSUM_EN
        .o_checksum  (o_checksum),
`endif
        .bus         (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [DW-1:0] mem [BN][BD];

    // Synchronous GLB: output register loads only on a read.
    always @(posedge i_clk) begin
        if (bus.o_glb_re) begin
            bus.i_glb_rd <= mem[bus.o_glb_bank_sel][bus.o_glb_ra];
        end
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 1;
        return 1'($urandom % 2);
    endfunction

    function automatic logic [DW-1:0] exp_word(input vec_t v, input int i);
        return mem[v.bank][(v.base + i) % BD];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, longint'(o_busy), 0);
        check({tag, "_done"}, longint'(o_done), 0);
        check({tag, "_re"}, longint'(bus.o_glb_re), 0);
        check({tag, "_valid"}, longint'(bus.o_valid), 0);
        check({tag, "_bank"}, longint'(bus.o_glb_bank_sel), 0);
    endtask

    task automatic run(input vec_t v);
        int issued = 0;
        int emitted = 0;
        int last_k = -1;
        int done_k = -1;
        int budget = v.num * 4 + 40;
        bit stall = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] sum = '0;
        @(negedge i_clk);
        i_bank = BW'(v.bank);
        i_base_addr = AW'(v.base);
        i_num_elem = LW'(v.num);
        i_start = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (v.restart && k == 2) begin
                i_start = 1'b1;
                i_base_addr = AW'(v.base ^ 'h155);
                i_num_elem = LW'(v.num + 3);
                i_bank = BW'((v.bank + 1) % BN);
            end
            bus.i_ready = pick_ready(v.rmode, k);
            if (k == 1 && v.num > 0) begin
                check("busy_start", longint'(o_busy), 1);
            end
            if (bus.o_glb_re) begin
                check("ra", longint'(bus.o_glb_ra), (v.base + issued) % BD);
                check("bank", longint'(bus.o_glb_bank_sel), v.bank);
                issued++;
            end
            if (stall) begin
                check("stall_valid", longint'(bus.o_valid), 1);
                check("stall_data", longint'(bus.o_data), longint'(held));
            end
            if (bus.o_last && !bus.o_valid) begin
                check("last_no_valid", longint'(bus.o_last), 0);
            end
            if (bus.o_valid) begin
                check("last", longint'(bus.o_last),
                      longint'(emitted == v.num - 1));
                if (bus.i_ready) begin
                    check("data", longint'(bus.o_data),
                          longint'(exp_word(v, emitted)));
                    sum = sum + bus.o_data;
                    emitted++;
                    if (bus.o_last) begin
                        last_k = k;
                        if (v.restart) i_start = 1'b1;
                    end
                end
            end
            check("outstanding", longint'(issued - emitted <= 3), 1);
            stall = bus.o_valid && !bus.i_ready;
            held = bus.o_data;
            if (o_done) begin
                done_k = k;
                break;
            end
        end
        check("done_seen", longint'(done_k > 0), 1);
        check("issued", issued, v.num);
        check("emitted", emitted, v.num);
        if (v.num == 0) begin
            check("done_lat0", done_k, 1);
        end else begin
            check("done_lat", done_k, last_k + 1);
        end
        if (v.rmode == 0 && v.num > 0) begin
            check("last_lat", last_k, v.num + 2);
        end
`ifdef GLB_PSUM_READER_CHECKSUM_EN
        check("checksum", longint'(o_checksum), longint'(sum));
`endif
        i_start = 1'b0;
        @(negedge i_clk);
        check_idle("after_done");
    endtask

    vec_t tbl [7];

    initial begin
        vec_t v;
        vec_t ab;
        n_cmp = 0;
        n_bad = 0;
        bus.i_ready = 1'b0;
        for (int b = 0; b < BN; b++) begin
            for (int a = 0; a < BD; a++) begin
                mem[b][a] = $urandom;
            end
        end
        mem[1][0] = 32'h10;
        mem[1][1] = 32'h20;
        mem[1][2] = 32'h30;
        mem[1][3] = 32'h40;

        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_idle("reset");
        check("reset_ra", longint'(bus.o_glb_ra), 0);
        check("reset_data", longint'(bus.o_data), 0);
        check("reset_last", longint'(bus.o_last), 0);
        i_rst = 1'b1;

        tbl[0] = '{bank: 1, base: 0,    num: 4,    rmode: 0, restart: 0};
        tbl[1] = '{bank: 0, base: 8190, num: 4,    rmode: 0, restart: 0};
        tbl[2] = '{bank: 2, base: 100,  num: 6,    rmode: 1, restart: 0};
        tbl[3] = '{bank: 1, base: 50,   num: 0,    rmode: 0, restart: 0};
        tbl[4] = '{bank: 2, base: 8191, num: 5,    rmode: 2, restart: 0};
        tbl[5] = '{bank: 1, base: 200,  num: 5,    rmode: 0, restart: 1};
        tbl[6] = '{bank: 0, base: 8189, num: 8195, rmode: 0, restart: 0};
        for (int i = 0; i < 7; i++) begin
            run(tbl[i]);
        end
`ifdef GLB_PSUM_READER_CHECKSUM_EN
        // Known stream 0x10..0x40 once more: sum must be 0xA0.
        run(tbl[0]);
        check("checksum_a0", longint'(o_checksum), 'hA0);
`endif

        // Reset while 7 of 10 words are still outstanding.
        ab = '{bank: 2, base: 300, num: 10, rmode: 0, restart: 0};
        @(negedge i_clk);
        i_bank = 2'd2;
        i_base_addr = 13'd300;
        i_num_elem = 14'd10;
        i_start = 1'b1;
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (k >= 3) begin
                check("abort_data", longint'(bus.o_data),
                      longint'(exp_word(ab, k - 3)));
            end
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_idle("abort");
        check("abort_ra", longint'(bus.o_glb_ra), 0);
        check("abort_data0", longint'(bus.o_data), 0);
        check("abort_last", longint'(bus.o_last), 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("abort_no_done", longint'(o_done), 0);
        v = '{bank: 0, base: 4000, num: 7, rmode: 0, restart: 0};
        run(v);

        for (int r = 0; r < 10; r++) begin
            v.bank = $urandom_range(0, BN - 1);
            v.base = $urandom_range(0, BD - 1);
            v.num = $urandom_range(0, 24);
            v.rmode = $urandom_range(0, 2);
            v.restart = 1'($urandom % 2);
            run(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
